// File: rtl/ntt_core_gf64_twd_mult.sv
// ntt_core_gf64_twd_mult
//   Twiddle-multiply stage behind a radix-column network stage of the GF64 NTT.
//   Every lane computes (in_data * in_twd) mod p, with p = 2^64 - 2^32 + 1, in a
//   fixed-latency pipeline. The batch/level/stage sideband and pbs id travel
//   alongside the data. A sticky framing checker flags malformed delimiters.
//
//   Latency LAT = IN_PIPE + MULT_LAT + 2 cycles, one beat accepted every cycle.
//
// Ports
//   clk, s_rst_n      clock, asynchronous active-low reset
//   in_data           PSI*R operands of OP_W bits (value congruent mod p)
//   in_twd            PSI*R twiddles of 64 bits (< p)
//   in_avail          per-lane valid
//   in_sob..in_eos    batch/level/stage delimiters, qualified by in_avail[0]
//   in_pbs_id         pbs id of the current beat
//   out_data          reduced products in [0,p), zero-extended to OP_W
//   out_avail         in_avail delayed by LAT
//   out_sob..out_eos  qualified delimiters delayed by LAT
//   out_pbs_id        in_pbs_id delayed by LAT
//   out_err           sticky: [0] sob inside batch, [1] eob outside batch,
//                     [2] in_avail lanes disagree
module ntt_core_gf64_twd_mult #(
    parameter int   PSI       = 2,
    parameter int   R         = 2,
    parameter int   BPBS_ID_W = 8,
    parameter int   OP_W      = 66,
    parameter logic IN_PIPE   = 1'b1,
    parameter int   MULT_LAT  = 3
) (
    input  logic                   clk,
    input  logic                   s_rst_n,
    input  logic [PSI*R*OP_W-1:0]  in_data,
    input  logic [PSI*R*64-1:0]    in_twd,
    input  logic [PSI*R-1:0]       in_avail,
    input  logic                   in_sob,
    input  logic                   in_eob,
    input  logic                   in_sol,
    input  logic                   in_eol,
    input  logic                   in_sos,
    input  logic                   in_eos,
    input  logic [BPBS_ID_W-1:0]   in_pbs_id,
    output logic [PSI*R*OP_W-1:0]  out_data,
    output logic [PSI*R-1:0]       out_avail,
    output logic                   out_sob,
    output logic                   out_eob,
    output logic                   out_sol,
    output logic                   out_eol,
    output logic                   out_sos,
    output logic                   out_eos,
    output logic [BPBS_ID_W-1:0]   out_pbs_id,
    output logic [2:0]             out_err
);

    localparam int N   = PSI * R;
    localparam int IP  = IN_PIPE ? 1 : 0;
    localparam int LAT = IP + MULT_LAT + 2;
    localparam int PW  = OP_W + 64;
    localparam int CW  = N + 6 + BPBS_ID_W;

    localparam logic [66:0] P67  = 67'h0_FFFF_FFFF_0000_0001;
    localparam logic [66:0] P2X  = 67'h1_FFFF_FFFE_0000_0002;

    // ------------------------------------------------------------------
    // Control pipe: {pbs_id, flags, avail}, reset domain, shifts every cycle.
    // Flags are qualified by in_avail[0] on entry.
    // ------------------------------------------------------------------
    logic [CW-1:0]          ctrl_in;
    logic [LAT-1:0][CW-1:0] ctrl_q;

    assign ctrl_in = {in_pbs_id,
                      {in_sob, in_eob, in_sol, in_eol, in_sos, in_eos} & {6{in_avail[0]}},
                      in_avail};

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q[0] <= ctrl_in;
            for (int unsigned k = 1; k < LAT; k++) begin
                ctrl_q[k] <= ctrl_q[k-1];
            end
        end
    end

    assign out_avail                                          = ctrl_q[LAT-1][N-1:0];
    assign {out_sob, out_eob, out_sol, out_eol, out_sos, out_eos} = ctrl_q[LAT-1][N+5:N];
    assign out_pbs_id                                         = ctrl_q[LAT-1][CW-1:N+6];

    // Enable of the data register at pipeline index k is the avail of the
    // beat entering that register.
    logic [LAT-1:0][N-1:0] reg_en;

    always_comb begin
        reg_en    = '0;
        reg_en[0] = in_avail;
        for (int unsigned k = 1; k < LAT; k++) begin
            reg_en[k] = ctrl_q[k-1][N-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Per-lane datapath (not reset; gated by lane avail).
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [OP_W-1:0] mi_data;
        logic [63:0]     mi_twd;

        if (IN_PIPE) begin : g_in_pipe
            logic [OP_W-1:0] data_q;
            logic [63:0]     twd_q;

            always_ff @(posedge clk) begin
                if (reg_en[0][g]) begin
                    data_q <= in_data[g*OP_W +: OP_W];
                    twd_q  <= in_twd[g*64 +: 64];
                end
            end

            assign mi_data = data_q;
            assign mi_twd  = twd_q;
        end else begin : g_in_direct
            assign mi_data = in_data[g*OP_W +: OP_W];
            assign mi_twd  = in_twd[g*64 +: 64];
        end

        // Product computed once, then carried through MULT_LAT registers so
        // synthesis can retime the multiplier across them.
        logic [PW-1:0]                prod;
        logic [MULT_LAT-1:0][PW-1:0]  prod_q;

        assign prod = PW'(mi_data) * PW'(mi_twd);

        always_ff @(posedge clk) begin
            if (reg_en[IP][g]) begin
                prod_q[0] <= prod;
            end
            for (int unsigned j = 1; j < MULT_LAT; j++) begin
                if (reg_en[IP+j][g]) begin
                    prod_q[j] <= prod_q[j-1];
                end
            end
        end

        // Reduce stage 1: 2^64 = 2^32-1, 2^96 = -1, 2^128 = -2^32 (mod p).
        logic [129:0] pe;
        logic [63:0]  c0;
        logic [31:0]  c1;
        logic [31:0]  c2;
        logic [1:0]   c3;
        logic [63:0]  c1x;
        logic [66:0]  r1;
        logic [66:0]  r1_q;

        assign pe  = 130'(prod_q[MULT_LAT-1]);
        assign c0  = pe[63:0];
        assign c1  = pe[95:64];
        assign c2  = pe[127:96];
        assign c3  = pe[129:128];
        assign c1x = {c1, 32'b0} - {32'b0, c1};
        assign r1  = {3'b0, c0} + {3'b0, c1x} - {35'b0, c2} - {33'b0, c3, 32'b0};

        always_ff @(posedge clk) begin
            if (reg_en[IP+MULT_LAT][g]) begin
                r1_q <= r1;
            end
        end

        // Reduce stage 2: r1 lies in (-2^35, 2p), so one correction suffices.
        logic [66:0]     fix;
        logic [OP_W-1:0] red_q;

        always_comb begin
            fix = r1_q;
            if (r1_q[66]) begin
                fix = r1_q + P67;
            end else if (r1_q >= P2X) begin
                fix = r1_q - P2X;
            end else if (r1_q >= P67) begin
                fix = r1_q - P67;
            end
        end

        always_ff @(posedge clk) begin
            if (reg_en[LAT-1][g]) begin
                red_q <= OP_W'(fix[63:0]);
            end
        end

        assign out_data[g*OP_W +: OP_W] = red_q;
    end

    // ------------------------------------------------------------------
    // Framing checker
    // ------------------------------------------------------------------
    typedef enum logic {IDLE, IN_BATCH} state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] err_set;

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q <= IDLE;
            out_err <= '0;
        end else begin
            state_q <= state_d;
            out_err <= out_err | err_set;
        end
    end

    always_comb begin
        state_d = state_q;
        err_set = '0;
        if (in_avail[0]) begin
            case (state_q)
                IDLE: begin
                    if (in_sob) begin
                        if (!in_eob) begin
                            state_d = IN_BATCH;
                        end
                    end else if (in_eob) begin
                        err_set[1] = 1'b1;
                    end
                end
                IN_BATCH: begin
                    if (in_sob) begin
                        err_set[0] = 1'b1;
                    end
                    if (in_eob) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (in_avail != '0 && in_avail != '1) begin
            err_set[2] = 1'b1;
        end
    end

endmodule
